// File: rtl/sd_blk_reader.sv
// CMD17 single-sector reader: drives the SPI master's CPU register port
// ($1 data, $2 control) and streams the 512 data bytes into a sector buffer.
module sd_blk_reader #(
    parameter int R1_LIMIT    = 255,
    parameter int TOKEN_LIMIT = 4095,
    parameter int GUARD       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [31:0] lba,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  r1,
    output logic        spi_cs,
    output logic        spi_rw,
    output logic [2:0]  spi_ad,
    output logic [7:0]  spi_wdata,
    input  logic [7:0]  spi_rdata,
    output logic        buf_we,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_wdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TAIL, S_DESEL, S_FIN
    } state_t;

    // Sub-steps of one byte transfer; SEL reuses PH_WR/PH_GAP for its write.
    typedef enum logic [2:0] {
        PH_WR, PH_GAP, PH_POLL, PH_PWAIT, PH_RD, PH_RWAIT
    } phase_t;

    localparam int CNT_TOP0 = (TOKEN_LIMIT > 512) ? TOKEN_LIMIT : 512;
    localparam int CNT_TOP  = (R1_LIMIT > CNT_TOP0) ? R1_LIMIT : CNT_TOP0;
    localparam int CW       = $clog2(CNT_TOP + 1);
    localparam int GW       = $clog2(GUARD + 1);

    localparam logic [CW-1:0] CMD_LAST   = CW'(5);
    localparam logic [CW-1:0] R1_LAST    = CW'(R1_LIMIT - 1);
    localparam logic [CW-1:0] TOKEN_LAST = CW'(TOKEN_LIMIT - 1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(511);
    localparam logic [CW-1:0] CRC_LAST   = CW'(1);
    localparam logic [GW-1:0] GUARD_MAX  = GW'(GUARD);

    localparam logic [2:0] AD_DATA    = 3'd1;
    localparam logic [2:0] AD_CTRL    = 3'd2;
    localparam logic [7:0] CTRL_SEL   = 8'h20;
    localparam logic [7:0] CTRL_DESEL = 8'h21;

    localparam logic [1:0] E_R1_TO  = 2'd1;
    localparam logic [1:0] E_BAD    = 2'd2;
    localparam logic [1:0] E_TOK_TO = 2'd3;

    state_t          r_state, w_state;
    phase_t          r_phase, w_phase;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [GW-1:0]   r_guard, w_guard;
    logic            r_seen0, w_seen0;
    logic [31:0]     r_lba, w_lba;
    logic            r_err, w_err;
    logic [1:0]      r_err_code, w_err_code;
    logic [7:0]      r_r1, w_r1;
    logic [7:0]      w_tx;
    logic [CW-1:0]   w_cnt_inc;

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state    <= S_IDLE;
            r_phase    <= PH_WR;
            r_cnt      <= '0;
            r_guard    <= '0;
            r_seen0    <= 1'b0;
            r_lba      <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_r1       <= 8'hFF;
        end else begin
            r_state    <= w_state;
            r_phase    <= w_phase;
            r_cnt      <= w_cnt;
            r_guard    <= w_guard;
            r_seen0    <= w_seen0;
            r_lba      <= w_lba;
            r_err      <= w_err;
            r_err_code <= w_err_code;
            r_r1       <= w_r1;
        end
    end

    always_comb begin
        w_tx = 8'hFF;
        if (r_state == S_CMD) begin
            case (r_cnt[2:0])
                3'd0:    w_tx = 8'h51;
                3'd1:    w_tx = r_lba[31:24];
                3'd2:    w_tx = r_lba[23:16];
                3'd3:    w_tx = r_lba[15:8];
                3'd4:    w_tx = r_lba[7:0];
                3'd5:    w_tx = 8'h95;
                default: w_tx = 8'hFF;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
        w_state    = r_state;
        w_phase    = r_phase;
        w_cnt      = r_cnt;
        w_guard    = r_guard;
        w_seen0    = r_seen0;
        w_lba      = r_lba;
        w_err      = r_err;
        w_err_code = r_err_code;
        w_r1       = r_r1;
        spi_cs     = 1'b0;
        spi_rw     = 1'b1;
        spi_ad     = 3'd0;
        spi_wdata  = 8'hFF;
        buf_we     = 1'b0;
        buf_wdata  = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_state    = S_SEL;
                    w_phase    = PH_WR;
                    w_cnt      = '0;
                    w_lba      = lba;
                    w_err      = 1'b0;
                    w_err_code = 2'd0;
                    w_r1       = 8'hFF;
                end
            end
            S_SEL: begin
                if (r_phase == PH_WR) begin
                    spi_cs    = 1'b1;
                    spi_rw    = 1'b0;
                    spi_ad    = AD_CTRL;
                    spi_wdata = CTRL_SEL;
                    w_phase   = PH_GAP;
                end else begin
                    w_state = S_CMD;
                    w_phase = PH_WR;
                    w_cnt   = '0;
                end
            end
            S_DESEL: begin
                spi_cs    = 1'b1;
                spi_rw    = 1'b0;
                spi_ad    = AD_CTRL;
                spi_wdata = CTRL_DESEL;
                w_state   = S_FIN;
            end
            S_FIN: begin
                w_state = S_IDLE;
            end
            default: begin
                case (r_phase)
                    PH_WR: begin
                        spi_cs    = 1'b1;
                        spi_rw    = 1'b0;
                        spi_ad    = AD_DATA;
                        spi_wdata = w_tx;
                        w_guard   = '0;
                        w_seen0   = 1'b0;
                        w_phase   = PH_GAP;
                    end
                    PH_GAP: w_phase = PH_POLL;
                    PH_POLL: begin
                        spi_cs  = 1'b1;
                        spi_ad  = AD_CTRL;
                        w_guard = (r_guard == GUARD_MAX) ? r_guard : r_guard + 1'b1;
                        w_phase = PH_PWAIT;
                    end
                    PH_PWAIT: begin
                        // RDY must fall then rise; a transfer that never shows RDY=0 is taken as finished.
                        if (r_seen0) begin
                            w_phase = spi_rdata[7] ? PH_RD : PH_POLL;
                        end else if (!spi_rdata[7]) begin
                            w_seen0 = 1'b1;
                            w_phase = PH_POLL;
                        end else begin
                            w_phase = (r_guard >= GUARD_MAX) ? PH_RD : PH_POLL;
                        end
                    end
                    PH_RD: begin
                        spi_cs  = 1'b1;
                        spi_ad  = AD_DATA;
                        w_phase = PH_RWAIT;
                    end
                    default: w_phase = PH_WR;
                endcase

                if (r_phase == PH_RWAIT) begin
                    w_cnt = w_cnt_inc;
                    case (r_state)
                        S_CMD: begin
                            if (r_cnt == CMD_LAST) begin
                                w_state = S_R1;
                                w_cnt   = '0;
                            end
                        end
                        S_R1: begin
                            if (!spi_rdata[7]) begin
                                w_r1  = spi_rdata;
                                w_cnt = '0;
                                if (spi_rdata == 8'h00) begin
                                    w_state = S_TOKEN;
                                end else begin
                                    w_err      = 1'b1;
                                    w_err_code = E_BAD;
                                    w_state    = S_TAIL;
                                end
                            end else if (r_cnt == R1_LAST) begin
                                w_err      = 1'b1;
                                w_err_code = E_R1_TO;
                                w_state    = S_TAIL;
                                w_cnt      = '0;
                            end
                        end
                        S_TOKEN: begin
                            if (spi_rdata == 8'hFE) begin
                                w_state = S_DATA;
                                w_cnt   = '0;
                            end else if (spi_rdata != 8'hFF) begin
                                w_err      = 1'b1;
                                w_err_code = E_BAD;
                                w_state    = S_TAIL;
                                w_cnt      = '0;
                            end else if (r_cnt == TOKEN_LAST) begin
                                w_err      = 1'b1;
                                w_err_code = E_TOK_TO;
                                w_state    = S_TAIL;
                                w_cnt      = '0;
                            end
                        end
                        S_DATA: begin
                            buf_we    = 1'b1;
                            buf_wdata = spi_rdata;
                            if (r_cnt == DATA_LAST) begin
                                w_state = S_CRC;
                                w_cnt   = '0;
                            end
                        end
                        S_CRC: begin
                            if (r_cnt == CRC_LAST) begin
                                w_state = S_TAIL;
                                w_cnt   = '0;
                            end
                        end
                        default: begin
                            w_state = S_DESEL;
                            w_cnt   = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done     = (r_state == S_FIN);
    assign err      = r_err;
    assign err_code = r_err_code;
    assign r1       = r_r1;
    assign buf_addr = (r_state == S_DATA) ? r_cnt[8:0] : 9'd0;

endmodule
